rom_load_seq: RTL and testbench



---
 rtl/rom_load_seq.sv | 148 ++++++++++++++
 tb/tb_rom_load_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_seq.sv
// Purpose: steer HPS ioctl downloads onto the core ROM write port, capture the title number, and hold the core in reset until a clean image has loaded.
// Latency: a byte sampled on edge n appears on ROMEN/ROMAD/ROMDT in cycle n+1; RUN is entered HOLD_CYC+1 edges after the DL_ACT fall is sampled.
// Backpressure: none; one byte per DL_WR cycle, back-to-back, and DL_ACT edges seen during HOLD are ignored.
module rom_load_seq #(
    parameter int AW       = 17,
    parameter int HOLD_CYC = 16
) (
    input  logic          MCLK,
    input  logic          RESET_N,
    input  logic          DL_ACT,
    input  logic          DL_WR,
    input  logic [7:0]    DL_IDX,
    input  logic [24:0]   DL_ADDR,
    input  logic [7:0]    DL_DATA,
    output logic [AW-1:0] ROMAD,
    output logic [7:0]    ROMDT,
    output logic          ROMEN,
    output logic [3:0]    TNO,
    output logic          CORE_RST,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic [15:0]   CSUM
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          act_q;
    logic [HW-1:0] hold_q;
    logic [AW:0]   cnt_q;

    logic act_rise;
    logic act_fall;
    logic in_load;
    logic in_range;
    logic rom_wr;
    logic rom_ok;
    logic dl_start;

    // The edge is taken between the registered and the live level, so the
    // state moves on the same clock edge that first samples the new level.
    assign act_rise = DL_ACT & ~act_q;
    assign act_fall = ~DL_ACT & act_q;
    assign in_load  = (state_q == ST_LOAD);
    assign in_range = ((DL_ADDR >> AW) == 25'd0);
    assign rom_wr   = in_load & DL_WR & (DL_IDX == 8'd0);
    assign rom_ok   = rom_wr & in_range;
    assign dl_start = ((state_q == ST_WAIT) || (state_q == ST_RUN)) & act_rise;

    // Next-state decode and state-derived core controls.
    always_comb begin
        state_d  = state_q;
        CORE_RST = 1'b1;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (act_rise) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                BUSY = 1'b1;
                if (act_fall) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                BUSY = 1'b1;
                if (hold_q == '0) begin
                    state_d = (!ERR && (cnt_q != '0)) ? ST_RUN : ST_WAIT;
                end
            end
            ST_RUN: begin
                CORE_RST = 1'b0;
                DONE     = 1'b1;
                if (act_rise) state_d = ST_LOAD;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // State register, DL_ACT history and the post-load hold counter.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_WAIT;
            act_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= DL_ACT;
            if (in_load && act_fall) begin
                hold_q <= HW'(HOLD_CYC - 1);
            end else if ((state_q == ST_HOLD) && (hold_q != '0)) begin
                hold_q <= hold_q - 1'b1;
            end
        end
    end

    // ROM write port: a one-cycle strobe per accepted byte; address/data hold otherwise.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ROMEN <= 1'b0;
            ROMAD <= '0;
            ROMDT <= '0;
        end else begin
            ROMEN <= rom_ok;
            if (rom_ok) begin
                ROMAD <= DL_ADDR[AW-1:0];
                ROMDT <= DL_DATA;
            end
        end
    end

    // Image bookkeeping: checksum, saturating byte count and sticky range error.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            CSUM  <= '0;
            cnt_q <= '0;
            ERR   <= 1'b0;
        end else if (dl_start) begin
            CSUM  <= '0;
            cnt_q <= '0;
            ERR   <= 1'b0;
        end else if (rom_ok) begin
            CSUM <= CSUM + {8'd0, DL_DATA};
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end else if (rom_wr) begin
            ERR <= 1'b1;
        end
    end

    // Title number from index-1 writes; the last one in a download wins.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            TNO <= '0;
        end else if (in_load && DL_WR && (DL_IDX == 8'd1)) begin
            TNO <= DL_DATA[3:0];
        end
    end

endmodule

// File: tb/tb_rom_load_seq.sv
// Purpose: randomized self-checking bench for rom_load_seq against a byte-level download model.
// Latency: expects each accepted byte on ROMEN one cycle after it is presented, RUN HOLD_CYC+1 edges after the fall.
// Backpressure: none; stimulus issues writes back-to-back or with random gaps.
module tb_rom_load_seq;

    localparam int AW    = 17;
    localparam int HC    = 16;
    localparam int ROMSZ = 1 << AW;

    logic          MCLK    = 1'b0;
    logic          RESET_N = 1'b1;
    logic          DL_ACT  = 1'b0;
    logic          DL_WR   = 1'b0;
    logic [7:0]    DL_IDX  = 8'd0;
    logic [24:0]   DL_ADDR = 25'd0;
    logic [7:0]    DL_DATA = 8'd0;
    logic [AW-1:0] ROMAD;
    logic [7:0]    ROMDT;
    logic          ROMEN;
    logic [3:0]    TNO;
    logic          CORE_RST;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic [15:0]   CSUM;

    rom_load_seq #(.AW(AW), .HOLD_CYC(HC)) dut (
        .MCLK(MCLK), .RESET_N(RESET_N), .DL_ACT(DL_ACT), .DL_WR(DL_WR),
        .DL_IDX(DL_IDX), .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA),
        .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN), .TNO(TNO),
        .CORE_RST(CORE_RST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CSUM(CSUM)
    );

    always #5 MCLK = ~MCLK;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the list of bytes the core should see, plus image totals.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t      exp_q[$];
    wr_t      mon_e;
    int       m_csum   = 0;
    int       m_cnt    = 0;
    int       m_pulses = 0;
    bit       m_err    = 1'b0;
    bit       m_load   = 1'b0;
    bit [3:0] m_tno    = 4'd0;
    bit       acc_now  = 1'b0;
    bit       acc_q    = 1'b0;
    int       romen_cnt = 0;
    int       base_cnt  = 0;

    // Whether the byte sampled on the last edge should be strobing now.
    always @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) acc_q <= 1'b0;
        else          acc_q <= acc_now;
    end

    // Every cycle: the strobe must match the model, and its payload the next expected byte.
    always @(negedge MCLK) begin
        chk("romen", ROMEN, acc_q);
        if (ROMEN === 1'b1) begin
            romen_cnt++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("romad", ROMAD, mon_e.a);
                chk("romdt", ROMDT, mon_e.d);
            end
        end
    end

    task automatic tick();
        @(posedge MCLK);
        #2;
    endtask

    task automatic wr_set(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        wr_t e;
        DL_WR   = 1'b1;
        DL_IDX  = idx;
        DL_ADDR = addr;
        DL_DATA = data;
        acc_now = m_load && (idx == 8'd0) && (addr < ROMSZ);
        if (acc_now) begin
            e.a = addr[AW-1:0];
            e.d = data;
            exp_q.push_back(e);
            m_csum = (m_csum + int'(data)) % 65536;
            if (m_cnt < ROMSZ) m_cnt++;
            m_pulses++;
        end
        if (m_load && (idx == 8'd0) && (addr >= ROMSZ)) m_err = 1'b1;
        if (m_load && (idx == 8'd1)) m_tno = data[3:0];
    endtask

    task automatic wr(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        wr_set(idx, addr, data);
        tick();
    endtask

    task automatic idle();
        DL_WR   = 1'b0;
        acc_now = 1'b0;
        tick();
    endtask

    task automatic start_dl();
        base_cnt = romen_cnt;
        m_pulses = 0;
        DL_ACT   = 1'b1;
        tick();
        m_load = 1'b1;
        m_err  = 1'b0;
        m_csum = 0;
        m_cnt  = 0;
        chk("busy_load", BUSY, 1);
        chk("rst_load", CORE_RST, 1);
        chk("done_load", DONE, 0);
        chk("csum_clr", CSUM, 0);
    endtask

    // Drops DL_ACT (possibly with a write still presented) and checks the hold/run outcome.
    task automatic finish_dl();
        int n;
        bit exp_run;
        bit last_acc;
        last_acc = acc_now;
        DL_ACT   = 1'b0;
        tick();
        DL_WR   = 1'b0;
        acc_now = 1'b0;
        m_load  = 1'b0;
        chk("romen_hold1", ROMEN, last_acc);
        chk("busy_hold", BUSY, 1);
        chk("rst_hold", CORE_RST, 1);
        exp_run = !m_err && (m_cnt != 0);
        n = 1;
        if (exp_run) begin
            while (CORE_RST === 1'b1 && n < HC + 20) begin
                tick();
                n++;
            end
            chk("rst_release_cyc", n, HC + 1);
        end else begin
            repeat (HC + 3) tick();
        end
        chk("done", DONE, exp_run);
        chk("core_rst", CORE_RST, !exp_run);
        chk("busy_end", BUSY, 0);
        chk("err", ERR, m_err);
        chk("csum", CSUM, m_csum);
        chk("tno", TNO, m_tno);
        chk("romen_count", romen_cnt - base_cnt, m_pulses);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_romad"}, ROMAD, 0);
        chk({tag, "_romdt"}, ROMDT, 0);
        chk({tag, "_romen"}, ROMEN, 0);
        chk({tag, "_tno"}, TNO, 0);
        chk({tag, "_core_rst"}, CORE_RST, 1);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_err"}, ERR, 0);
        chk({tag, "_csum"}, CSUM, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int cnt_snap;
        logic [24:0] a;

        // Reset state.
        #1 RESET_N = 1'b0;
        repeat (3) tick();
        chk_reset_vals("rst");
        RESET_N = 1'b1;
        tick();

        // Four-byte image: expect sum 0x000A and RUN.
        start_dl();
        for (int i = 0; i < 4; i++) begin
            wr(8'd0, 25'(i), 8'(i + 1));
            idle();
        end
        finish_dl();
        chk("csum_four", CSUM, 16'h000A);

        // Out-of-range address: byte dropped, ERR set, back to WAIT.
        repeat (3) idle();
        start_dl();
        wr(8'd0, 25'd5, 8'h11);
        wr(8'd0, 25'h20000, 8'h22);
        wr(8'd0, 25'd6, 8'h33);
        idle();
        finish_dl();
        chk("err_range", ERR, 1);

        // A clean random image to reach RUN again.
        repeat (3) idle();
        start_dl();
        for (int i = 0; i < 40; i++) begin
            wr(8'd0, 25'($urandom_range(ROMSZ - 1, 0)), 8'($urandom));
            if ($urandom_range(1, 0) == 1) idle();
        end
        idle();
        finish_dl();

        // Writes outside LOAD are ignored, including the title index.
        wr(8'd1, 25'd0, 8'h5A);
        wr(8'd0, 25'd7, 8'h77);
        idle();
        chk("tno_outside", TNO, m_tno);
        chk("done_outside", DONE, 1);

        // Title-only download from RUN: TNO=3, no bytes, ends in WAIT.
        repeat (2) idle();
        start_dl();
        wr(8'd1, 25'd0, 8'h23);
        idle();
        finish_dl();
        chk("tno_title", TNO, 4'd3);

        // 1000 back-to-back bytes, last one coincident with the DL_ACT fall.
        repeat (3) idle();
        start_dl();
        for (int i = 0; i < 999; i++) begin
            wr(8'd0, 25'($urandom_range(ROMSZ - 1, 0)), 8'($urandom));
        end
        wr_set(8'd0, 25'($urandom_range(ROMSZ - 1, 0)), 8'($urandom));
        finish_dl();
        chk("burst_pulses", m_pulses, 1000);

        // Mixed random downloads: assorted indices, gaps, occasional bad addresses.
        for (int t = 0; t < 4; t++) begin
            repeat (3) idle();
            start_dl();
            for (int i = 0; i < 120; i++) begin
                r = $urandom_range(99, 0);
                if (t >= 2 && r < 2)  a = 25'(ROMSZ + $urandom_range(1000, 0));
                else                  a = 25'($urandom_range(ROMSZ - 1, 0));
                if (r >= 90)      wr(8'd1, a, 8'($urandom));
                else if (r >= 85) wr(8'($urandom_range(255, 2)), a, 8'($urandom));
                else              wr(8'd0, a, 8'($urandom));
                if ($urandom_range(3, 0) == 0) idle();
            end
            idle();
            finish_dl();
        end

        // Reset in the middle of a download: immediate reset values, pending strobe dropped.
        repeat (3) idle();
        start_dl();
        for (int i = 0; i < 10; i++) begin
            wr(8'd0, 25'(i + 100), 8'($urandom));
        end
        RESET_N = 1'b0;
        DL_WR   = 1'b0;
        DL_ACT  = 1'b0;
        acc_now = 1'b0;
        #1;
        exp_q.delete();
        cnt_snap = romen_cnt;
        m_load = 1'b0;
        m_err  = 1'b0;
        m_csum = 0;
        m_cnt  = 0;
        m_tno  = 4'd0;
        chk_reset_vals("midrst");
        repeat (3) tick();
        RESET_N = 1'b1;
        repeat (3) tick();
        chk("romen_after_rst", romen_cnt - cnt_snap, 0);
        chk("wait_after_rst", CORE_RST, 1);

        // Full download after the reset completes normally.
        start_dl();
        for (int i = 0; i < 30; i++) begin
            wr(8'd0, 25'($urandom_range(ROMSZ - 1, 0)), 8'($urandom));
        end
        idle();
        finish_dl();
        chk("done_after_rst", DONE, 1);

        repeat (2) idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
